fc_layer_seq: RTL and testbench

- Parametrised address/control sequencer for one fully-connected layer.
- Each chunk step presents LANES input activations and LANES weights to the 16-way MAC/ALU, accumulates IN_LEN/LANES chunks per output neuron, then writes the truncated result for that neuron into the next layer's RAM.
- Generalises the fixed 16-lane/512-input/256-output layer-2 controller with run-time start/done, stall, configurable sizes and a configurable writeback latency.

---
 rtl/fc_layer_seq.sv | 157 +++++++++++++++
 tb/tb_fc_layer_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: address/control sequencer for one fully-connected layer.
// Each RUN cycle issues one chunk of LANES activations/weights to the MAC.
// IN_LEN/LANES chunks make up one output neuron. A PIPE_LAT-deep delay line
// turns each neuron's final chunk into a write strobe for the next-layer RAM.
module fc_layer_seq #(
    parameter int LANES    = 16,
    parameter int IN_LEN   = 512,
    parameter int OUT_LEN  = 256,
    parameter int IN_AW    = 9,
    parameter int OUT_AW   = 8,
    parameter int WADDR_W  = 17,
    parameter int PIPE_LAT = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stall_i,
    output logic [IN_AW-1:0]   in_addr_o,
    output logic [WADDR_W-1:0] w_addr_o,
    output logic [OUT_AW-1:0]  b_addr_o,
    output logic               bias_ena_o,
    output logic               acc_last_o,
    output logic               wr_en_o,
    output logic [OUT_AW-1:0]  wr_addr_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [IN_AW-1:0]   LAST_IN  = IN_AW'(IN_LEN - LANES);
    localparam logic [IN_AW-1:0]   STEP     = IN_AW'(LANES);
    localparam logic [OUT_AW-1:0]  LAST_B   = OUT_AW'(OUT_LEN - 1);
    localparam logic [WADDR_W-1:0] IN_LEN_W = WADDR_W'(IN_LEN);

    logic [1:0]         state_q, state_d;
    logic [IN_AW-1:0]   in_addr_q, in_addr_d;
    logic [OUT_AW-1:0]  b_addr_q, b_addr_d;

    // Delay line: one {last, neuron} entry per stage, stage PIPE_LAT-1 is the output.
    logic [PIPE_LAT-1:0]             dl_last_q, dl_last_d;
    logic [PIPE_LAT-1:0][OUT_AW-1:0] dl_addr_q, dl_addr_d;

    logic run;
    logic advance;
    logic is_first;
    logic is_last;
    logic pending;

    assign run      = (state_q == S_RUN);
    assign advance  = ~stall_i;
    assign is_first = (in_addr_q == '0);
    assign is_last  = (in_addr_q == LAST_IN);

    // Chunk-level outputs are only meaningful while issuing, so gate them by RUN.
    always_comb begin
        bias_ena_o = run & is_first;
        acc_last_o = run & is_last;
        w_addr_o   = '0;
        if (run) begin
            w_addr_o = WADDR_W'(b_addr_q) * IN_LEN_W + WADDR_W'(in_addr_q);
        end
    end

    // A write is still in flight if any stage ahead of the output stage holds one.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < PIPE_LAT - 1; i++) begin
            pending = pending | dl_last_q[i];
        end
    end

    // Sequencer: walk chunks within a neuron, then neurons, then drain the pipe.
    always_comb begin
        state_d   = state_q;
        in_addr_d = in_addr_q;
        b_addr_d  = b_addr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_RUN;
                    in_addr_d = '0;
                    b_addr_d  = '0;
                end
            end
            S_RUN: begin
                if (advance) begin
                    if (is_last) begin
                        if (b_addr_q == LAST_B) begin
                            state_d = S_DRAIN;
                        end else begin
                            in_addr_d = '0;
                            b_addr_d  = b_addr_q + 1'b1;
                        end
                    end else begin
                        in_addr_d = in_addr_q + STEP;
                    end
                end
            end
            S_DRAIN: begin
                if (advance && !pending) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                in_addr_d = '0;
                b_addr_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Shift the delay line one stage per unstalled cycle, feeding the current chunk in.
    always_comb begin
        dl_last_d = dl_last_q;
        dl_addr_d = dl_addr_q;
        if (advance) begin
            dl_last_d[0] = run & is_last;
            dl_addr_d[0] = b_addr_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_last_d[i] = dl_last_q[i-1];
                dl_addr_d[i] = dl_addr_q[i-1];
            end
        end
    end

    // State, counters and delay line registers; reset aborts any run in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            in_addr_q <= '0;
            b_addr_q  <= '0;
            dl_last_q <= '0;
            dl_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            in_addr_q <= in_addr_d;
            b_addr_q  <= b_addr_d;
            dl_last_q <= dl_last_d;
            dl_addr_q <= dl_addr_d;
        end
    end

    assign in_addr_o = in_addr_q;
    assign b_addr_o  = b_addr_q;
    assign wr_en_o   = dl_last_q[PIPE_LAT-1] & ~stall_i;
    assign wr_addr_o = dl_addr_q[PIPE_LAT-1];
    assign busy_o    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o    = (state_q == S_DONE);

endmodule

// File: tb/tb_fc_layer_seq.sv
// Testbench for fc_layer_seq: a small configuration checked every cycle against
// a chunk/neuron-level reference model, plus a default-size instance for full-run counts.
module tb_fc_layer_seq;

    localparam int LANES    = 4;
    localparam int IN_LEN   = 16;
    localparam int OUT_LEN  = 3;
    localparam int PIPE_LAT = 2;
    localparam int IN_AW    = 4;
    localparam int OUT_AW   = 2;
    localparam int WADDR_W  = 6;
    localparam int CH       = IN_LEN / LANES;
    localparam int TOTAL    = OUT_LEN * CH;

    localparam int D_LANES = 16;
    localparam int D_IN    = 512;
    localparam int D_OUT   = 256;
    localparam int D_PIPE  = 2;

    logic clk = 1'b0;
    logic rstN;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic defStart = 1'b0;
    logic defStall = 1'b0;

    logic [IN_AW-1:0]   inAddr;
    logic [WADDR_W-1:0] wAddr;
    logic [OUT_AW-1:0]  bAddr;
    logic               biasEna, accLast, wrEn, busy, done;
    logic [OUT_AW-1:0]  wrAddr;

    logic [8:0]  dInAddr;
    logic [16:0] dWAddr;
    logic [7:0]  dBAddr;
    logic        dBiasEna, dAccLast, dWrEn, dBusy, dDone;
    logic [7:0]  dWrAddr;

    int assertCount = 0;
    int failCount   = 0;
    bit checkEn     = 1'b0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    fc_layer_seq #(
        .LANES(LANES), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .IN_AW(IN_AW),
        .OUT_AW(OUT_AW), .WADDR_W(WADDR_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .stall_i(stall),
        .in_addr_o(inAddr), .w_addr_o(wAddr), .b_addr_o(bAddr),
        .bias_ena_o(biasEna), .acc_last_o(accLast), .wr_en_o(wrEn),
        .wr_addr_o(wrAddr), .busy_o(busy), .done_o(done)
    );

    fc_layer_seq dutDef (
        .clk_i(clk), .rst_ni(rstN), .start_i(defStart), .stall_i(defStall),
        .in_addr_o(dInAddr), .w_addr_o(dWAddr), .b_addr_o(dBAddr),
        .bias_ena_o(dBiasEna), .acc_last_o(dAccLast), .wr_en_o(dWrEn),
        .wr_addr_o(dWrAddr), .busy_o(dBusy), .done_o(dDone)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a chunk counter plus a queue of neurons awaiting writeback,
    // each with the number of unstalled cycles left before its write appears.
    typedef struct {
        int n;
        int rem;
    } wrItem_t;

    wrItem_t wrQ[$];
    int mMode  = 0;   // 0 idle, 1 issuing, 2 draining, 3 done pulse
    int mChunk = 0;

    // Advance the model on each clock edge; an asynchronous reset empties it.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mMode  = 0;
            mChunk = 0;
            wrQ.delete();
        end else begin
            if (!stall) begin
                if (wrQ.size() > 0 && wrQ[0].rem == 0) begin
                    void'(wrQ.pop_front());
                end
                for (int i = 0; i < wrQ.size(); i++) begin
                    wrQ[i].rem = wrQ[i].rem - 1;
                end
            end
            case (mMode)
                0: begin
                    if (start) begin
                        mMode  = 1;
                        mChunk = 0;
                    end
                end
                1: begin
                    if (!stall) begin
                        if (mChunk % CH == CH - 1) begin
                            wrItem_t it;
                            it.n   = mChunk / CH;
                            it.rem = PIPE_LAT - 1;
                            wrQ.push_back(it);
                        end
                        if (mChunk == TOTAL - 1) mMode = 2;
                        else mChunk = mChunk + 1;
                    end
                end
                2: begin
                    if (!stall && wrQ.size() == 0) mMode = 3;
                end
                default: mMode = 0;
            endcase
        end
    end

    int  ckK, ckN;
    bit  ckRun, ckWr;

    // Compare every output of the small instance against the model mid-cycle.
    always @(negedge clk) begin
        if (checkEn) begin
            ckK   = mChunk % CH;
            ckN   = mChunk / CH;
            ckRun = (mMode == 1);
            ckWr  = !stall && wrQ.size() > 0 && wrQ[0].rem == 0;
            checkOutput("inAddr", inAddr, (mMode == 0) ? 0 : ckK * LANES);
            checkOutput("bAddr", bAddr, (mMode == 0) ? 0 : ckN);
            checkOutput("wAddr", wAddr, ckRun ? ckN * IN_LEN + ckK * LANES : 0);
            checkOutput("biasEna", biasEna, ckRun && ckK == 0);
            checkOutput("accLast", accLast, ckRun && ckK == CH - 1);
            checkOutput("wrEn", wrEn, ckWr);
            if (ckWr) checkOutput("wrAddr", wrAddr, wrQ[0].n);
            checkOutput("busy", busy, mMode == 1 || mMode == 2);
            checkOutput("done", done, mMode == 3);
        end
    end

    int evWr[8], evWrA[8], evBias[8], evLast[8], evDone[8];
    int nWr, nBias, nLast, nDone, nBusy;

    // One run from a start pulse, with an optional stall window and extra start pulses.
    task automatic applyStimulus(input int stallAt, input int stallLen, input int extraStartAt);
        nWr = 0; nBias = 0; nLast = 0; nDone = 0; nBusy = 0;
        @(posedge clk); #1;
        start = 1'b1;
        stall = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            start = (c == 5) || (c == extraStartAt);
            stall = (c >= stallAt) && (c < stallAt + stallLen);
            @(negedge clk);
            if (wrEn)    begin if (nWr < 8)   begin evWr[nWr] = c; evWrA[nWr] = int'(wrAddr); end nWr++; end
            if (biasEna) begin if (nBias < 8) evBias[nBias] = c; nBias++; end
            if (accLast) begin if (nLast < 8) evLast[nLast] = c; nLast++; end
            if (done)    begin if (nDone < 8) evDone[nDone] = c; nDone++; end
            if (busy)    nBusy++;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic checkEvents(input string tag, input int n, input int g0, input int g1,
                               input int g2, input int e0, input int e1, input int e2);
        checkOutput({tag, "Count"}, n, 3);
        checkOutput({tag, "0"}, g0, e0);
        checkOutput({tag, "1"}, g1, e1);
        checkOutput({tag, "2"}, g2, e2);
    endtask

    int cnt;
    int doneAt, dBusyCnt, dBiasCnt, dLastCnt, dWrCnt, dDoneCnt, dLastWrA, dMaxW;
    bit seen;

    initial begin
        rstN = 1'b1;
        #2 rstN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstWrEn", wrEn, 0);
        checkOutput("rstInAddr", inAddr, 0);
        checkOutput("rstWAddr", wAddr, 0);
        checkEn = 1'b1;
        @(posedge clk); #1 rstN = 1'b1;
        repeat (2) @(posedge clk);

        // Clean run, extra starts during RUN and during the DONE cycle.
        applyStimulus(0, 0, 15);
        checkEvents("bias", nBias, evBias[0], evBias[1], evBias[2], 1, 5, 9);
        checkEvents("last", nLast, evLast[0], evLast[1], evLast[2], 4, 8, 12);
        checkEvents("wrCyc", nWr, evWr[0], evWr[1], evWr[2], 6, 10, 14);
        checkEvents("wrAddrSeq", nWr, evWrA[0], evWrA[1], evWrA[2], 0, 1, 2);
        checkOutput("doneCount", nDone, 1);
        checkOutput("doneCycle", evDone[0], 15);
        checkOutput("busyCycles", nBusy, 14);

        // Three stalled cycles starting where in_addr=8, b_addr=1.
        applyStimulus(7, 3, 18);
        checkEvents("stBias", nBias, evBias[0], evBias[1], evBias[2], 1, 5, 12);
        checkEvents("stLast", nLast, evLast[0], evLast[1], evLast[2], 4, 11, 15);
        checkEvents("stWrCyc", nWr, evWr[0], evWr[1], evWr[2], 6, 13, 17);
        checkEvents("stWrAddr", nWr, evWrA[0], evWrA[1], evWrA[2], 0, 1, 2);
        checkOutput("stDoneCount", nDone, 1);
        checkOutput("stDoneCycle", evDone[0], 18);

        // Reset in the middle of neuron 1 aborts the run.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bAddr == 1) seen = 1'b1;
        end
        checkOutput("reachNeuron1", seen, 1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstInAddr", inAddr, 0);
        checkOutput("midRstBAddr", bAddr, 0);
        checkOutput("midRstAccLast", accLast, 0);
        @(posedge clk); #1 rstN = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (wrEn || busy || done) cnt++;
        end
        checkOutput("postRstActivity", cnt, 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        checkOutput("restartInAddr", inAddr, 0);
        checkOutput("restartBAddr", bAddr, 0);
        checkOutput("restartBias", biasEna, 1);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput("restartDone", seen, 1);

        // Random starts, stalls and occasional resets, checked by the model.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 5) == 0);
            stall = ($urandom_range(0, 3) == 0);
            rstN  = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        stall = 1'b0;
        rstN  = 1'b1;
        repeat (40) @(posedge clk);

        // Default-size layer: full run statistics.
        @(posedge clk); #1 defStart = 1'b1;
        @(posedge clk); #1 defStart = 1'b0;
        doneAt = 0; dBusyCnt = 0; dBiasCnt = 0; dLastCnt = 0; dWrCnt = 0;
        dDoneCnt = 0; dLastWrA = -1; dMaxW = 0;
        for (int c = 1; c <= 8400; c++) begin
            @(negedge clk);
            if (dBusy) dBusyCnt++;
            if (dBiasEna) dBiasCnt++;
            if (dAccLast) dLastCnt++;
            if (int'(dWAddr) > dMaxW) dMaxW = int'(dWAddr);
            if (dWrEn) begin dWrCnt++; dLastWrA = int'(dWrAddr); end
            if (dDone) begin dDoneCnt++; if (doneAt == 0) doneAt = c; end
            if (doneAt != 0 && c > doneAt + 5) break;
        end
        checkOutput("defBusyCycles", dBusyCnt, D_OUT * D_IN / D_LANES + D_PIPE);
        checkOutput("defDoneCycle", doneAt, D_OUT * D_IN / D_LANES + D_PIPE + 1);
        checkOutput("defBiasCount", dBiasCnt, D_OUT);
        checkOutput("defLastCount", dLastCnt, D_OUT);
        checkOutput("defWrCount", dWrCnt, D_OUT);
        checkOutput("defLastWrAddr", dLastWrA, D_OUT - 1);
        checkOutput("defFinalWAddr", dMaxW, (D_OUT - 1) * D_IN + D_IN - D_LANES);
        checkOutput("defDoneCount", dDoneCnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #2000000;
        failCount++;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
